mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single-port unified memory between instruction fetch (IF) and load/store (LS).
//  Grants at most one request per cycle, drives the memory port and returns read data to the
//  owning requester after a fixed latency. Sits between Core pipeline ports and the memory array.
// PARAMETERS
//  ADDR_W      16  word address width (memory is 64K words)
//  DATA_W      32  data width; byte enables are DATA_W/8 bits
//  RD_LAT      1   memory read latency in cycles (>=1)
//  STARVE_MAX  4   consecutive denied IF cycles before IF gets forced priority (>=1)
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst           in   1          reset, asynchronous, active-high
//  if_req_valid  in   1          fetch request
//  if_req_ready  out  1          fetch request accepted this cycle
//  if_req_addr   in   ADDR_W     fetch word address
//  if_rsp_valid  out  1          fetch data valid (1 cycle pulse)
//  if_rsp_data   out  DATA_W     fetch data
//  ls_req_valid  in   1          load/store request
//  ls_req_ready  out  1          load/store request accepted this cycle
//  ls_req_we     in   1          1 = store, 0 = load
//  ls_req_be     in   DATA_W/8   store byte enables
//  ls_req_addr   in   ADDR_W     load/store word address
//  ls_req_wdata  in   DATA_W     store data
//  ls_rsp_valid  out  1          load data valid (1 cycle pulse; never for stores)
//  ls_rsp_data   out  DATA_W     load data
//  mem_en        out  1          memory access this cycle
//  mem_we        out  1          memory write
//  mem_be        out  DATA_W/8   memory byte enables
//  mem_addr      out  ADDR_W     memory address
//  mem_wdata     out  DATA_W     memory write data
//  mem_rdata     in   DATA_W     memory read data, valid RD_LAT cycles after mem_en
// BEHAVIOUR
//  - Transfer = valid & ready in same cycle. ready is combinational, may depend on other valid.
//  - Default priority LS > IF. starve_cnt counts cycles with if_req_valid & !if_req_ready;
//    when starve_cnt == STARVE_MAX, IF wins the next contended cycle; counter clears on any IF grant
//    and on cycles with if_req_valid low. Counter saturates at STARVE_MAX.
//  - Exactly one of if_req_ready/ls_req_ready high when any valid; both low when neither valid.
//  - mem_* combinational from granted request; mem_en=0, mem_we=0 when no grant. IF grant: mem_we=0.
//  - Owner tag pipeline (RD_LAT deep) records IF/LS/NONE for each grant; LS stores enter NONE.
//  - Response: at tag pipe output, pulse owner's rsp_valid for one cycle, rsp_data = mem_rdata.
//    Other requester's rsp_valid low; rsp_data of non-owner holds last value.
//  - Throughput 1 access/cycle; responses return in grant order, no reordering, no backpressure
//    on responses (requesters must always accept).
//  - Reset (async, any time): starve_cnt=0, tag pipe all NONE, rsp_valid=0, rsp_data=0;
//    in-flight reads are dropped, no response issued after reset releases.
//  - Inputs stable while valid & !ready; arbiter does not latch unaccepted requests.
// STRUCTURE
//  - mem_arb_pkg: owner enum OWN_NONE=2'd0, OWN_IF=2'd1, OWN_LS=2'd2; default width constants.
//  - Sub-module arb_tag_pipe: RD_LAT-deep shift register of owner tags, async reset to OWN_NONE.
//  - Top: grant logic, starve counter, mem mux, response demux.
// TESTING
//  1 IF only: addr 0x0010 every cycle, mem[0x10]=0x00500093 -> ready=1 each cycle,
//    if_rsp_valid RD_LAT later with 0x00500093, ls_rsp_valid stays 0.
//  2 LS load 0x0100 and IF 0x0011 same cycle -> ls granted, mem_addr=0x0100;
//    IF granted next cycle; ls_rsp then if_rsp in order.
//  3 LS store be=4'b0011 wdata=0xDEADBEEF at 0x0200 -> mem_we=1, mem_be=0011; no rsp pulse;
//    later load 0x0200 returns low half 0xBEEF merged with prior upper half.
//  4 LS valid continuously, IF valid continuously, STARVE_MAX=4 -> IF granted on 5th contended cycle,
//    then LS resumes; pattern repeats every 5 cycles.
//  5 rst pulse one cycle after IF grant with RD_LAT=2 -> no if_rsp_valid after reset; outputs 0.
//  6 No valids for 10 cycles -> mem_en=0, both ready=0, starve_cnt stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
package mem_arb_pkg;

    // Owner of an in-flight memory access; NONE also covers stores and idle cycles.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 32;
    localparam int RD_LAT_DEF     = 1;
    localparam int STARVE_MAX_DEF = 4;

    // Bits needed to hold a counter that saturates at max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag delay line: a tag entering with a grant leaves DEPTH cycles later,
// lined up with the memory read data for that grant.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = RD_LAT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stage [DEPTH];

    // Shift tags one stage per cycle; reset empties the pipe so dropped reads never answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port memory and
// routes read data back to whichever requester owned the access.
//
// Handshake: a request transfers in the cycle where its valid and ready are both
// high. ready is combinational and may depend on the other requester's valid;
// requesters hold their inputs stable while valid & !ready. Responses carry no
// ready: the owner's rsp_valid pulses for one cycle and must be consumed then.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_req_we,
    input  logic [DATA_W/8-1:0] ls_req_be,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          if_gnt;
    logic          ls_gnt;
    owner_t        tag_in;
    owner_t        tag_out;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] ls_hold;

    // Grant: LS normally wins; a fetch that has waited STARVE_MAX cycles takes the next slot.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (if_req_valid && (!ls_req_valid || starve_cnt == STARVE_LIM)) begin
            if_gnt = 1'b1;
        end else if (ls_req_valid) begin
            ls_gnt = 1'b1;
        end
    end

    assign if_req_ready = if_gnt;
    assign ls_req_ready = ls_gnt;

    // Count consecutive refused fetch cycles, saturating; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req_valid || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Memory port mux driven straight from the winning request; idle port is all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_in    = OWN_NONE;
        if (ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_req_we;
            mem_be    = ls_req_be;
            mem_addr  = ls_req_addr;
            mem_wdata = ls_req_wdata;
            tag_in    = ls_req_we ? OWN_NONE : OWN_LS;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_req_addr;
            tag_in   = OWN_IF;
        end
    end

    arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign if_rsp_valid = (tag_out == OWN_IF);
    assign ls_rsp_valid = (tag_out == OWN_LS);

    // Remember each requester's last returned word so its data bus holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_hold <= '0;
            ls_hold <= '0;
        end else begin
            if (if_rsp_valid) if_hold <= mem_rdata;
            if (ls_rsp_valid) ls_hold <= mem_rdata;
        end
    end

    assign if_rsp_data = if_rsp_valid ? mem_rdata : if_hold;
    assign ls_rsp_data = ls_rsp_valid ? mem_rdata : ls_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by random
// traffic, checked against a word-level reference memory and priority model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam int QW         = DATA_W + 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              if_v, if_req_ready, if_rsp_valid;
    logic [ADDR_W-1:0] if_a;
    logic [DATA_W-1:0] if_rsp_data;
    logic              ls_v, ls_req_ready, ls_we, ls_rsp_valid;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_a;
    logic [DATA_W-1:0] ls_wd, ls_rsp_data;
    logic              mem_en, mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_v), .if_req_ready(if_req_ready), .if_req_addr(if_a),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_v), .ls_req_ready(ls_req_ready), .ls_req_we(ls_we),
        .ls_req_be(ls_be), .ls_req_addr(ls_a), .ls_req_wdata(ls_wd),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        if (a == 16'h0010) return 32'h0050_0093;
        return {a, ~a} ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory array the DUT drives ----------------
    bit   [DATA_W-1:0] mem_arr [65536];
    bit                written [65536];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic [DATA_W-1:0] rd_word, wr_word;

    always_comb begin
        rd_word = written[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);
        wr_word = rd_word;
        for (int b = 0; b < BE_W; b++)
            if (mem_be[b]) wr_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= wr_word;
            written[mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [65536];
    int                if_wait;
    logic [QW-1:0]     exp_q[$];
    int                checks = 0;
    int                fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One request cycle: predict the winner from the priority rules, check the
    // handshake and memory port, then account the access in the reference model.
    task automatic step(output logic gi, output logic gl, output logic dut_ifg);
        #1;
        gi = if_v && (!ls_v || if_wait >= STARVE_MAX);
        gl = ls_v && !gi;
        check("if_ready", if_req_ready, gi);
        check("ls_ready", ls_req_ready, gl);
        check("mem_en", mem_en, gi || gl);
        check("mem_we", mem_we, gl && ls_we);
        if (gi) check("mem_addr_if", mem_addr, if_a);
        if (gl) check("mem_addr_ls", mem_addr, ls_a);
        if (gl && ls_we) begin
            check("mem_be", mem_be, ls_be);
            check("mem_wdata", mem_wdata, ls_wd);
        end
        dut_ifg = if_req_ready;
        if (gi) begin
            exp_q.push_back({OWN_IF, ref_mem[if_a]});
            if_wait = 0;
        end else if (if_v) begin
            if_wait = (if_wait < STARVE_MAX) ? if_wait + 1 : STARVE_MAX;
        end else begin
            if_wait = 0;
        end
        if (gl) begin
            if (ls_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (ls_be[b]) ref_mem[ls_a][b*8 +: 8] = ls_wd[b*8 +: 8];
            end else begin
                exp_q.push_back({OWN_LS, ref_mem[ls_a]});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic gi, gl, d;
        if_v = 1'b0;
        ls_v = 1'b0;
        for (int i = 0; i < n; i++) step(gi, gl, d);
    endtask

    // ---------------- response monitor ----------------
    logic [DATA_W-1:0] last_if, last_ls;
    initial begin
        last_if = '0;
        last_ls = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                last_if = '0;
                last_ls = '0;
            end else begin
                check("rsp_onehot", {63'd0, if_rsp_valid & ls_rsp_valid}, 64'd0);
                if (if_rsp_valid || ls_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL rsp_unexpected: if_valid=%0b ls_valid=%0b expected none",
                                 if_rsp_valid, ls_rsp_valid);
                    end else begin
                        logic [QW-1:0] e;
                        e = exp_q.pop_front();
                        if (if_rsp_valid)
                            check("if_rsp", {OWN_IF, if_rsp_data}, e);
                        else
                            check("ls_rsp", {OWN_LS, ls_rsp_data}, e);
                    end
                end
                if (!if_rsp_valid) check("if_rsp_hold", if_rsp_data, last_if);
                if (!ls_rsp_valid) check("ls_rsp_hold", ls_rsp_data, last_ls);
                last_if = if_rsp_data;
                last_ls = ls_rsp_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic gi, gl, d;
        int   n_if;
        rst = 1'b1;
        if_v = 1'b0; if_a = '0;
        ls_v = 1'b0; ls_we = 1'b0; ls_be = '0; ls_a = '0; ls_wd = '0;
        if_wait = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(ADDR_W'(i));
        @(negedge clk);
        @(negedge clk);
        check("rst_if_rsp_valid", if_rsp_valid, 1'b0);
        check("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
        check("rst_if_rsp_data", if_rsp_data, '0);
        check("rst_ls_rsp_data", ls_rsp_data, '0);
        check("rst_mem_en", mem_en, 1'b0);
        rst = 1'b0;

        // IF alone streams 0x0010
        if_v = 1'b1; if_a = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            step(gi, gl, d);
            check("t1_if_ready", d, 1'b1);
        end
        idle(RD_LAT + 1);

        // Simultaneous load and fetch: load first, fetch next cycle
        if_v = 1'b1; if_a = 16'h0011;
        ls_v = 1'b1; ls_we = 1'b0; ls_a = 16'h0100;
        step(gi, gl, d);
        check("t2_ls_first", {ls_req_ready, d}, 2'b10);
        ls_v = 1'b0;
        step(gi, gl, d);
        check("t2_if_second", d, 1'b1);
        idle(RD_LAT + 1);

        // Partial store then load back the merged word
        ls_v = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_a = 16'h0200; ls_wd = 32'hDEAD_BEEF;
        step(gi, gl, d);
        ls_we = 1'b0;
        step(gi, gl, d);
        ls_v = 1'b0;
        check("t3_merge_ref", ref_mem[16'h0200], {init_val(16'h0200) >> 16, 16'hBEEF});
        idle(RD_LAT + 1);

        // Idle period: port quiet, no readies
        idle(10);

        // Continuous contention: fetch wins every fifth cycle
        n_if = 0;
        if_v = 1'b1; if_a = 16'h0020;
        ls_v = 1'b1; ls_we = 1'b0; ls_a = 16'h0030;
        for (int k = 0; k < 15; k++) begin
            step(gi, gl, d);
            check("t4_if_grant", d, (k % 5) == 4);
            if (d) n_if++;
        end
        check("t4_if_count", n_if, 3);
        idle(RD_LAT + 1);

        // Reset one cycle after a fetch grant drops the read
        if_v = 1'b1; if_a = 16'h0040;
        step(gi, gl, d);
        if_v = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        if_wait = 0;
        #1;
        check("t5_if_rsp_valid", if_rsp_valid, 1'b0);
        check("t5_if_rsp_data", if_rsp_data, '0);
        check("t5_ls_rsp_data", ls_rsp_data, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(RD_LAT + 2);

        // Random traffic with held requests
        for (int n = 0; n < 400; n++) begin
            if (!if_v && $urandom_range(0, 9) < 6) begin
                if_v = 1'b1;
                if_a = 16'h0300 + ADDR_W'($urandom_range(0, 31));
            end
            if (!ls_v && $urandom_range(0, 9) < 5) begin
                ls_v  = 1'b1;
                ls_we = 1'($urandom_range(0, 1));
                ls_be = BE_W'($urandom_range(0, 15));
                ls_a  = 16'h0300 + ADDR_W'($urandom_range(0, 15));
                ls_wd = $urandom;
            end
            step(gi, gl, d);
            if (gi) if_v = 1'b0;
            if (gl) ls_v = 1'b0;
        end
        idle(RD_LAT + 3);
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
